// File: rtl/wb_exc_ctrl_pkg.sv
// Shared definitions for the write-back exception/ERET commit controller:
// CP0 {rd,sel} register addresses, exception codes and FSM state encoding.
package wb_exc_ctrl_pkg;

  // CP0 register addresses as {rd[4:0], sel[2:0]}
  localparam logic [7:0] STATUS_ADDR  = 8'h60;  // rd=12, sel=0
  localparam logic [7:0] CAUSE_ADDR   = 8'h68;  // rd=13, sel=0
  localparam logic [7:0] EPC_ADDR     = 8'h70;  // rd=14, sel=0
  localparam logic [7:0] COUNT_ADDR   = 8'h48;  // rd=9,  sel=0
  localparam logic [7:0] COMPARE_ADDR = 8'h58;  // rd=11, sel=0

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // Controller state: IDLE evaluates WB, REDIR holds the PC redirect to IF
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } state_e;

endpackage

// File: rtl/wb_exc_ctrl_cp0_timer.sv
// CP0 Count/Compare timer. Count advances every second clock; a one-cycle
// match pulse is raised when Count equals Compare on a cycle Count updates.
// Only instantiated when WB_EXC_CP0_TIMER_EN is defined.
module cp0_timer
  import wb_exc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        count_eq_compare
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;
  logic        match_q, match_d;
  logic        count_upd;

  // Next timer state: software write to Count wins over the increment
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    tick_d    = ~tick_q;
    count_d   = count_q;
    compare_d = compare_q;
    count_upd = tick_q;
    if (tick_q) begin
      count_d = count_q + 32'd1;  // wraps silently at FFFFFFFF
    end
    if (wr_en && (wr_addr == COUNT_ADDR)) begin
      count_d   = wr_data;
      count_upd = 1'b1;
    end
    if (wr_en && (wr_addr == COMPARE_ADDR)) begin
      compare_d = wr_data;
    end
    match_d = count_upd & (count_d == compare_d);
  end

  // Timer registers; everything clears so reset can never raise a match
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      tick_q    <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
      match_q   <= match_d;
    end
  end

  assign count_eq_compare = match_q;

endmodule

// File: rtl/wb_exc_ctrl.sv
// Write-back exception/ERET commit controller sitting in front of CP0.
// Decides commit / trap / ERET for the retiring WB instruction, drives the
// CP0 strobes and a pipeline flush, and holds a PC redirect toward IF until
// it is accepted. Optional CP0 Count/Compare timer: WB_EXC_CP0_TIMER_EN.
module wb_exc_ctrl
  import wb_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC     = 32'hBFC00380,
  parameter logic [4:0]  INT_EXCCODE = 5'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ws_valid,
  input  logic        ws_ex,
  input  logic [4:0]  ws_exccode,
  input  logic        ws_bd,
  input  logic [31:0] ws_pc,
  input  logic        ws_eret,
  input  logic        ws_mtc0,
  input  logic [7:0]  ws_cp0_addr,
  input  logic [31:0] ws_wdata,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        redirect_ready,
  output logic        wb_ex,
  output logic [4:0]  wb_exccode,
  output logic        wb_bd,
  output logic [31:0] wb_pc,
  output logic        eret_reflush,
  output logic        mtc0_we,
  output logic [7:0]  cp0_addr,
  output logic [31:0] cp0_wdata,
  output logic        count_eq_compare,
  output logic        ws_flush,
  output logic        ws_busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  state_e      state_q, state_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        int_pend;
  logic        eval;
  logic        take_exc;
  logic        take_eret;
  logic        take_mtc0;

  // Only IE, EXL, IM and IP participate in interrupt detection
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_status[31:16], cp0_status[7:2],
                             cp0_cause[31:16], cp0_cause[7:0]};

  // Commit decision: interrupt > earlier-stage exception > ERET > MTC0
  always_comb begin
    int_pend  = cp0_status[0] & ~cp0_status[1] &
                (|(cp0_cause[15:8] & cp0_status[15:8]));
    eval      = (state_q == ST_IDLE) & ws_valid & ~rst;
    take_exc  = eval & (int_pend | ws_ex);
    take_eret = eval & ~(int_pend | ws_ex) & ws_eret;
    take_mtc0 = eval & ~(int_pend | ws_ex) & ~ws_eret & ws_mtc0;
  end

  // State and latched redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Next state: traps and ERET enter REDIR; the accepted handshake leaves it
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (take_exc) begin
          state_d       = ST_REDIR;
          redirect_pc_d = EXC_VEC;
        end else if (take_eret) begin
          state_d       = ST_REDIR;
          redirect_pc_d = cp0_epc;
        end
      end
      ST_REDIR: begin
        // redirect_valid is always high here, so ready alone completes it
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: all zero in reset; REDIR suppresses every commit strobe
  always_comb begin
    wb_ex          = 1'b0;
    wb_exccode     = '0;
    wb_bd          = 1'b0;
    wb_pc          = '0;
    eret_reflush   = 1'b0;
    mtc0_we        = 1'b0;
    cp0_addr       = '0;
    cp0_wdata      = '0;
    ws_flush       = 1'b0;
    ws_busy        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!rst) begin
      // CP0 qualifies these with mtc0_we, so they simply follow WB
      cp0_addr  = ws_cp0_addr;
      cp0_wdata = ws_wdata;
      if (state_q == ST_REDIR) begin
        redirect_valid = 1'b1;
        redirect_pc    = redirect_pc_q;
        ws_busy        = 1'b1;
        ws_flush       = 1'b1;  // keep wrong-path instructions from committing
      end else if (take_exc) begin
        wb_ex      = 1'b1;
        wb_exccode = int_pend ? INT_EXCCODE : ws_exccode;
        wb_bd      = ws_bd;
        wb_pc      = ws_pc;
        ws_flush   = 1'b1;
      end else if (take_eret) begin
        eret_reflush = 1'b1;
        ws_flush     = 1'b1;
      end else if (take_mtc0) begin
        mtc0_we = 1'b1;
      end
    end
  end

`ifdef WB_EXC_CP0_TIMER_EN
  logic timer_match;

  cp0_timer u_cp0_timer (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (mtc0_we),
    .wr_addr          (ws_cp0_addr),
    .wr_data          (ws_wdata),
    .count_eq_compare (timer_match)
  );

  assign count_eq_compare = timer_match & ~rst;
`else
  assign count_eq_compare = 1'b0;
`endif

endmodule

// File: tb/tb_wb_exc_ctrl.sv
// Self-checking bench for wb_exc_ctrl. Stimulus and expected output vectors
// are queued together; each cycle the next stimulus is applied and the
// observed outputs are compared with the popped expectation at negedge.
module tb_wb_exc_ctrl;

  localparam logic [31:0] EXC_VEC = 32'hBFC00380;

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic        ex;
    logic [4:0]  exccode;
    logic        bd;
    logic [31:0] pc;
    logic        eret;
    logic        mtc0;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        ready;
  } stim_t;

  typedef struct packed {
    logic        wb_ex;
    logic [4:0]  wb_exccode;
    logic        wb_bd;
    logic [31:0] wb_pc;
    logic        eret_reflush;
    logic        mtc0_we;
    logic [7:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        count_eq_compare;
    logic        ws_flush;
    logic        ws_busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
  } obs_t;

  logic        clk;
  logic        rst;
  logic        ws_valid;
  logic        ws_ex;
  logic [4:0]  ws_exccode;
  logic        ws_bd;
  logic [31:0] ws_pc;
  logic        ws_eret;
  logic        ws_mtc0;
  logic [7:0]  ws_cp0_addr;
  logic [31:0] ws_wdata;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic        redirect_ready;
  logic        wb_ex;
  logic [4:0]  wb_exccode;
  logic        wb_bd;
  logic [31:0] wb_pc;
  logic        eret_reflush;
  logic        mtc0_we;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        count_eq_compare;
  logic        ws_flush;
  logic        ws_busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  stim_t st[$];
  obs_t  sb[$];

  wb_exc_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .ws_valid         (ws_valid),
    .ws_ex            (ws_ex),
    .ws_exccode       (ws_exccode),
    .ws_bd            (ws_bd),
    .ws_pc            (ws_pc),
    .ws_eret          (ws_eret),
    .ws_mtc0          (ws_mtc0),
    .ws_cp0_addr      (ws_cp0_addr),
    .ws_wdata         (ws_wdata),
    .cp0_status       (cp0_status),
    .cp0_cause        (cp0_cause),
    .cp0_epc          (cp0_epc),
    .redirect_ready   (redirect_ready),
    .wb_ex            (wb_ex),
    .wb_exccode       (wb_exccode),
    .wb_bd            (wb_bd),
    .wb_pc            (wb_pc),
    .eret_reflush     (eret_reflush),
    .mtc0_we          (mtc0_we),
    .cp0_addr         (cp0_addr),
    .cp0_wdata        (cp0_wdata),
    .count_eq_compare (count_eq_compare),
    .ws_flush         (ws_flush),
    .ws_busy          (ws_busy),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic apply(input stim_t s);
    rst            = s.rst;
    ws_valid       = s.valid;
    ws_ex          = s.ex;
    ws_exccode     = s.exccode;
    ws_bd          = s.bd;
    ws_pc          = s.pc;
    ws_eret        = s.eret;
    ws_mtc0        = s.mtc0;
    ws_cp0_addr    = s.addr;
    ws_wdata       = s.wdata;
    cp0_status     = s.status;
    cp0_cause      = s.cause;
    cp0_epc        = s.epc;
    redirect_ready = s.ready;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.wb_ex            = wb_ex;
    o.wb_exccode       = wb_exccode;
    o.wb_bd            = wb_bd;
    o.wb_pc            = wb_pc;
    o.eret_reflush     = eret_reflush;
    o.mtc0_we          = mtc0_we;
    o.cp0_addr         = cp0_addr;
    o.cp0_wdata        = cp0_wdata;
    o.count_eq_compare = count_eq_compare;
    o.ws_flush         = ws_flush;
    o.ws_busy          = ws_busy;
    o.redirect_valid   = redirect_valid;
    o.redirect_pc      = redirect_pc;
    return o;
  endfunction

  function automatic stim_t mk(input logic valid, input logic [31:0] pc);
    stim_t s = '0;
    s.valid = valid;
    s.pc    = pc;
    return s;
  endfunction

  // Expected: IDLE cycle with nothing to do
  function automatic obs_t exp_idle(input stim_t s);
    obs_t o = '0;
    o.cp0_addr  = s.addr;
    o.cp0_wdata = s.wdata;
    return o;
  endfunction

  // Expected: holding the redirect toward IF
  function automatic obs_t exp_redir(input stim_t s, input logic [31:0] pc);
    obs_t o = exp_idle(s);
    o.ws_flush       = 1'b1;
    o.ws_busy        = 1'b1;
    o.redirect_valid = 1'b1;
    o.redirect_pc    = pc;
    return o;
  endfunction

  // Expected: trap commit cycle
  function automatic obs_t exp_exc(input stim_t s, input logic [4:0] code);
    obs_t o = exp_idle(s);
    o.wb_ex      = 1'b1;
    o.wb_exccode = code;
    o.wb_bd      = s.bd;
    o.wb_pc      = s.pc;
    o.ws_flush   = 1'b1;
    return o;
  endfunction

  task automatic push(input stim_t s, input obs_t e);
    st.push_back(s);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    stim_t s;
    obs_t  e, got;
    int    n = 0;
    s = mk(1, 32'hBFC00010);
    s.rst = 1'b1; s.ex = 1'b1; s.exccode = 5'h08; s.mtc0 = 1'b1;
    s.addr = 8'h60; s.wdata = 32'h1234; s.ready = 1'b1;
    push(s, '0);
    push(s, '0);
    while (st.size() > 0) begin
      apply(st.pop_front());
      @(negedge clk);
      e = sb.pop_front(); got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset[%0d] got=%h exp=%h", n, got, e);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_syscall();
    stim_t s, w, r, b, z;
    obs_t  e, got;
    int    n = 0;
    s = mk(1, 32'hBFC00010);
    s.ex = 1'b1; s.exccode = 5'h08; s.addr = 8'h11; s.wdata = 32'hDEAD0001;
    push(s, exp_exc(s, 5'h08));
    // wrong-path trapping instruction while redirect is stalled
    w = s; w.pc = 32'hBFC00014;
    for (int i = 0; i < 3; i++) push(w, exp_redir(w, EXC_VEC));
    r = w; r.ready = 1'b1;
    push(r, exp_redir(r, EXC_VEC));
    // first instruction after the redirect traps immediately
    b = mk(1, 32'hBFC00380);
    b.ex = 1'b1; b.exccode = 5'h04; b.bd = 1'b1;
    push(b, exp_exc(b, 5'h04));
    // ready already high on entry: REDIR lasts exactly one cycle
    z = mk(0, 32'h0); z.ready = 1'b1;
    push(z, exp_redir(z, EXC_VEC));
    push(z, exp_idle(z));
    while (st.size() > 0) begin
      apply(st.pop_front());
      @(negedge clk);
      e = sb.pop_front(); got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL syscall[%0d] got=%h exp=%h", n, got, e);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_interrupt();
    stim_t s, z, m;
    obs_t  e, got;
    int    n = 0;
    s = mk(1, 32'hBFC00200);
    s.status = 32'h0000_0401; s.cause = 32'h0000_0400;
    s.ex = 1'b1; s.exccode = 5'h0C; s.mtc0 = 1'b1; s.addr = 8'h60; s.wdata = 32'h1;
    push(s, exp_exc(s, 5'h00));
    z = mk(0, 32'h0); z.ready = 1'b1;
    push(z, exp_redir(z, EXC_VEC));
    // EXL set masks the interrupt
    m = mk(1, 32'hBFC00204); m.status = 32'h0000_0403; m.cause = 32'h0000_0400;
    push(m, exp_idle(m));
    // IM bit does not match the pending IP bit
    m.status = 32'h0000_0801;
    push(m, exp_idle(m));
    // pending interrupt with no valid instruction does nothing
    m = mk(0, 32'h0); m.status = 32'h0000_0401; m.cause = 32'h0000_0400;
    push(m, exp_idle(m));
    push(m, exp_idle(m));
    while (st.size() > 0) begin
      apply(st.pop_front());
      @(negedge clk);
      e = sb.pop_front(); got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL interrupt[%0d] got=%h exp=%h", n, got, e);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_eret();
    stim_t s, w, r, z, x;
    obs_t  e, got;
    int    n = 0;
    s = mk(1, 32'hBFC00300); s.eret = 1'b1; s.epc = 32'hBFC00124;
    e = exp_idle(s); e.eret_reflush = 1'b1; e.ws_flush = 1'b1;
    push(s, e);
    // epc changes after the ERET: redirect target must not follow it
    w = mk(0, 32'h0); w.epc = 32'h1234_5678;
    push(w, exp_redir(w, 32'hBFC00124));
    r = w; r.ready = 1'b1;
    push(r, exp_redir(r, 32'hBFC00124));
    z = mk(0, 32'h0);
    push(z, exp_idle(z));
    // exception beats ERET
    x = s; x.ex = 1'b1; x.exccode = 5'h09;
    push(x, exp_exc(x, 5'h09));
    push(r, exp_redir(r, EXC_VEC));
    push(z, exp_idle(z));
    while (st.size() > 0) begin
      apply(st.pop_front());
      @(negedge clk);
      e = sb.pop_front(); got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL eret[%0d] got=%h exp=%h", n, got, e);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_mtc0();
    stim_t s, z, x, r;
    obs_t  e, got;
    int    n = 0;
    s = mk(1, 32'hBFC00400); s.mtc0 = 1'b1; s.addr = 8'h60; s.wdata = 32'h0000_FF01;
    e = exp_idle(s); e.mtc0_we = 1'b1;
    push(s, e);
    z = mk(0, 32'h0);
    push(z, exp_idle(z));
    x = mk(1, 32'hBFC00404); x.ex = 1'b1; x.exccode = 5'h0A;
    push(x, exp_exc(x, 5'h0A));
    // MTC0 presented during REDIR must not write
    push(s, exp_redir(s, EXC_VEC));
    r = s; r.ready = 1'b1;
    push(r, exp_redir(r, EXC_VEC));
    push(z, exp_idle(z));
    while (st.size() > 0) begin
      apply(st.pop_front());
      @(negedge clk);
      e = sb.pop_front(); got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mtc0[%0d] got=%h exp=%h", n, got, e);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_timer();
    stim_t s;
    obs_t  e, got;
    int    n = 0;
    int    pulses = 0;
    int    first = -1;
    int    exp_pulses[$];
    s = mk(1, 32'hBFC00500); s.mtc0 = 1'b1; s.addr = 8'h58; s.wdata = 32'd5;
    e = exp_idle(s); e.mtc0_we = 1'b1;
    push(s, e);
    s.addr = 8'h48; s.wdata = 32'd0;
    e = exp_idle(s); e.mtc0_we = 1'b1;
    push(s, e);
`ifdef WB_EXC_CP0_TIMER_EN
    exp_pulses.push_back(1);
`else
    exp_pulses.push_back(0);
`endif
    while (st.size() > 0) begin
      apply(st.pop_front());
      @(negedge clk);
      e = sb.pop_front(); got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL timer_wr[%0d] got=%h exp=%h", n, got, e);
      end
      @(posedge clk); #1;
      n++;
    end
    apply(mk(0, 32'h0));
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (count_eq_compare === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (pulses !== exp_pulses[0]) begin
      errors++;
      $display("FAIL timer_pulses got=%0d exp=%0d", pulses, exp_pulses[0]);
    end
    void'(exp_pulses.pop_front());
`ifdef WB_EXC_CP0_TIMER_EN
    checks++;
    if (first < 8 || first > 11) begin
      errors++;
      $display("FAIL timer_latency got=%0d exp=8..11", first);
    end
`endif
  endtask

  task automatic test_rst_redir();
    stim_t x, w, r, z, p;
    obs_t  e, got;
    int    n = 0;
    x = mk(1, 32'hBFC00600); x.ex = 1'b1; x.exccode = 5'h05;
    push(x, exp_exc(x, 5'h05));
    w = mk(1, 32'hBFC00604); w.ex = 1'b1; w.exccode = 5'h0C;
    push(w, exp_redir(w, EXC_VEC));
    r = w; r.rst = 1'b1;
    push(r, '0);
    z = mk(0, 32'h0);
    push(z, exp_idle(z));
    p = mk(1, 32'hBFC00608);
    push(p, exp_idle(p));
    while (st.size() > 0) begin
      apply(st.pop_front());
      @(negedge clk);
      e = sb.pop_front(); got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rst_redir[%0d] got=%h exp=%h", n, got, e);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_interrupt();
    test_eret();
    test_mtc0();
    test_timer();
    test_rst_redir();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
